// File: rtl/adpll_cfg_master.sv
// adpll_cfg_master: bring-up sequencer that programs the ADPLL register block
// over a valid/ready bus, polls for lock and reports sticky status.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   start, stop                  1-cycle command pulses
//   fcw, mode                    channel word and loop mode, sampled on start
//   valid/address/wdata/wstrb    bus request (wstrb: 1=write, 0=read)
//   rdata/ready                  bus response
//   busy, done                   sequence in progress / end-of-sequence pulse
//   locked, sat, timeout, bus_err  sticky status, cleared on accepted start
module adpll_cfg_master #(
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 1000000,
  parameter int FCWW     = 26,
  parameter int ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] ADDR_SOFT_RST = 'h04,
  parameter logic [ADDR_W-1:0] ADDR_FCW      = 'h08,
  parameter logic [ADDR_W-1:0] ADDR_MODE     = 'h0C,
  parameter logic [ADDR_W-1:0] ADDR_EN       = 'h10,
  parameter logic [ADDR_W-1:0] ADDR_LOCK     = 'h14,
  parameter logic [ADDR_W-1:0] ADDR_SAT      = 'h18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [FCWW-1:0]   fcw,
  input  logic [1:0]        mode,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              wstrb,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              sat,
  output logic              timeout,
  output logic              bus_err
);

  localparam int PW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PLAST = PW'(POLL_GAP - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, W_RST1, W_RST0, W_FCW, W_MODE, W_EN,
    P_WAIT, R_LOCK, R_SAT, W_DIS, FIN
  } state_t;

  state_t            state, nxt;
  logic              gap, gap_n;
  logic [PW-1:0]     pcnt;
  logic [TW-1:0]     tcnt;
  logic              trun;
  logic              stop_pend;
  logic [DATA_W-1:0] rd_q;
  logic [FCWW-1:0]   fcw_q;
  logic [1:0]        mode_q;

  logic              valid_n, wstrb_n, busy_n, done_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  logic stop_any, rd_err, t_exp, p_end, bound, enter;
  logic acc_start, lock_set, tout_set, berr_set, sat_en, stop_act;

  // Bus states run a request phase (gap=0) then one gap cycle (gap=1);
  // all sequencing decisions are taken at the end of the gap cycle.
  function automatic logic is_bus(state_t s);
    return !(s == IDLE || s == P_WAIT || s == FIN);
  endfunction

  assign stop_any = stop_pend | stop;
  assign rd_err   = |rd_q[DATA_W-1:1];
  assign t_exp    = tcnt >= TMAX;
  assign p_end    = pcnt == PLAST;
  assign bound    = is_bus(state) && gap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap       <= 1'b0;
      pcnt      <= '0;
      tcnt      <= '0;
      trun      <= 1'b0;
      stop_pend <= 1'b0;
      rd_q      <= '0;
      fcw_q     <= '0;
      mode_q    <= '0;
      valid     <= 1'b0;
      address   <= '0;
      wdata     <= '0;
      wstrb     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      sat       <= 1'b0;
      timeout   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state   <= nxt;
      gap     <= gap_n;
      valid   <= valid_n;
      address <= addr_n;
      wdata   <= wdata_n;
      wstrb   <= wstrb_n;
      busy    <= busy_n;
      done    <= done_n;
      if (valid && ready) rd_q <= rdata;
      stop_pend <= stop_any &&
                   !(nxt inside {IDLE, W_DIS, FIN});
      if (state == P_WAIT) pcnt <= pcnt + 1'b1;
      else pcnt <= '0;
      if (state == W_EN && nxt == P_WAIT) begin
        tcnt <= '0;
        trun <= 1'b1;
      end else if (trun && !t_exp) begin
        tcnt <= tcnt + 1'b1;
      end
      if (acc_start) begin
        fcw_q   <= fcw;
        mode_q  <= mode;
        trun    <= 1'b0;
        locked  <= 1'b0;
        sat     <= 1'b0;
        timeout <= 1'b0;
        bus_err <= 1'b0;
      end else begin
        if (lock_set) locked  <= 1'b1;
        if (stop_act) locked  <= 1'b0;
        if (sat_en)   sat     <= rd_q[0];
        if (tout_set) timeout <= 1'b1;
        if (berr_set) bus_err <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt   = state;
    gap_n = gap;
    unique case (state)
      IDLE: begin
        if (stop) nxt = W_DIS;
        else if (start) nxt = W_RST1;
      end
      P_WAIT: begin
        if (stop_any) nxt = W_DIS;
        else if (p_end) nxt = R_LOCK;
      end
      FIN: nxt = IDLE;
      default: begin
        if (!gap) begin
          if (valid && ready) gap_n = 1'b1;
        end else begin
          gap_n = 1'b0;
          case (state)
            W_RST1: nxt = stop_any ? W_DIS : W_RST0;
            W_RST0: nxt = stop_any ? W_DIS : W_FCW;
            W_FCW:  nxt = stop_any ? W_DIS : W_MODE;
            W_MODE: nxt = stop_any ? W_DIS : W_EN;
            W_EN:   nxt = stop_any ? W_DIS : P_WAIT;
            R_LOCK: begin
              if (rd_err || stop_any) nxt = W_DIS;
              else if (rd_q[0]) nxt = R_SAT;
              else if (t_exp) nxt = W_DIS;
              else nxt = P_WAIT;
            end
            R_SAT: nxt = (rd_err || stop_any) ? W_DIS : FIN;
            default: nxt = FIN;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    enter   = is_bus(nxt) && (nxt != state);
    valid_n = valid;
    wstrb_n = wstrb;
    addr_n  = address;
    wdata_n = wdata;
    if (valid && ready) begin
      valid_n = 1'b0;
      wstrb_n = 1'b0;
    end
    if (enter) begin
      valid_n = 1'b1;
      wstrb_n = 1'b1;
      case (nxt)
        W_RST1: begin addr_n = ADDR_SOFT_RST; wdata_n = DATA_W'(1); end
        W_RST0: begin addr_n = ADDR_SOFT_RST; wdata_n = '0; end
        W_FCW:  begin addr_n = ADDR_FCW; wdata_n = DATA_W'(fcw_q); end
        W_MODE: begin addr_n = ADDR_MODE; wdata_n = DATA_W'(mode_q); end
        W_EN:   begin addr_n = ADDR_EN; wdata_n = DATA_W'(1); end
        R_LOCK: begin addr_n = ADDR_LOCK; wstrb_n = 1'b0; end
        R_SAT:  begin addr_n = ADDR_SAT; wstrb_n = 1'b0; end
        default: begin addr_n = ADDR_EN; wdata_n = '0; end
      endcase
    end
    busy_n    = !(nxt == IDLE || nxt == FIN);
    done_n    = nxt == FIN;
    acc_start = state == IDLE && start && !stop;
    lock_set  = bound && state == R_LOCK && nxt == R_SAT;
    tout_set  = bound && state == R_LOCK && !rd_err && !stop_any &&
                !rd_q[0] && t_exp;
    berr_set  = bound && (state == R_LOCK || state == R_SAT) && rd_err;
    sat_en    = bound && state == R_SAT && !rd_err;
    stop_act  = stop_any && nxt == W_DIS && state != W_DIS;
  end

endmodule

// File: tb/tb_adpll_cfg_master.sv
// tb_adpll_cfg_master: directed bench with a 1-cycle-latency responder
// model and an expected-transaction scoreboard.
module tb_adpll_cfg_master;

  localparam int PG = 4;
  localparam int TO = 50;
  localparam logic [7:0] A_RST  = 8'h04;
  localparam logic [7:0] A_FCW  = 8'h08;
  localparam logic [7:0] A_MODE = 8'h0C;
  localparam logic [7:0] A_EN   = 8'h10;
  localparam logic [7:0] A_LOCK = 8'h14;
  localparam logic [7:0] A_SAT  = 8'h18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [25:0] fcw = '0;
  logic [1:0] mode = '0;
  logic valid, wstrb, ready, busy, done;
  logic locked, sat, timeout, bus_err;
  logic [7:0] address;
  logic [31:0] wdata, rdata;

  adpll_cfg_master #(
    .DATA_W(32), .POLL_GAP(PG), .TIMEOUT(TO), .FCWW(26), .ADDR_W(8),
    .ADDR_SOFT_RST(A_RST), .ADDR_FCW(A_FCW), .ADDR_MODE(A_MODE),
    .ADDR_EN(A_EN), .ADDR_LOCK(A_LOCK), .ADDR_SAT(A_SAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .fcw(fcw), .mode(mode), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .busy(busy), .done(done), .locked(locked), .sat(sat),
    .timeout(timeout), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [31:0] d;
    int         c;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Responder behaviour knobs: lock on poll number lock_after (0 = never),
  // return all-ones on poll number err_poll (0 = never).
  int   lock_after = 1;
  int   err_poll = 0;
  logic sat_val = 1'b0;
  int   polls = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid && !ready;
      if (start) polls <= 0;
      if (valid && !ready && !wstrb) begin
        if (address == A_LOCK) begin
          polls <= polls + 1;
          if (err_poll == polls + 1) rdata <= 32'hFFFF_FFFF;
          else if (lock_after != 0 && polls + 1 >= lock_after)
            rdata <= 32'd1;
          else rdata <= 32'd0;
        end else if (address == A_SAT) begin
          rdata <= {31'b0, sat_val};
        end else begin
          rdata <= 32'hFFFF_FFFF;
        end
      end
    end
  end

  always @(negedge clk)
    if (!rst && valid && !ready)
      obs_q.push_back('{wstrb, address, wdata, cyc});

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input int c);
    exp_q.push_back('{wr, a, d, c});
  endtask

  task automatic push_seq(input int s, input logic [25:0] f,
                          input logic [1:0] m);
    push(1'b1, A_RST, 32'd1, s + 1);
    push(1'b1, A_RST, 32'd0, s + 4);
    push(1'b1, A_FCW, {6'b0, f}, s + 7);
    push(1'b1, A_MODE, {30'b0, m}, s + 10);
    push(1'b1, A_EN, 32'd1, s + 13);
  endtask

  task automatic drain(input string tag);
    txn_t o, e;
    int i;
    n_cmp++;
    assert (obs_q.size() == exp_q.size()) else begin
      n_bad++;
      $error("FAIL %s_count: observed %0d expected %0d",
             tag, obs_q.size(), exp_q.size());
    end
    i = 0;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s_dir%0d", tag, i), o.wr, e.wr);
      chk($sformatf("%s_addr%0d", tag, i), o.a, e.a);
      if (e.wr) chk($sformatf("%s_data%0d", tag, i), o.d, e.d);
      chk($sformatf("%s_cyc%0d", tag, i), o.c, e.c);
      i++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic kick(input logic [25:0] f, input logic [1:0] m,
                      input logic with_stop, input bit seq,
                      output int s);
    @(negedge clk);
    s = cyc;
    if (seq) push_seq(s, f, m);
    fcw = f;
    mode = m;
    start = 1'b1;
    stop = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int want);
    int dc;
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    chk({tag, "_done_cyc"}, dc, want);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic flags(input string tag, input logic l, input logic s,
                       input logic t, input logic b);
    chk({tag, "_locked"}, locked, l);
    chk({tag, "_sat"}, sat, s);
    chk({tag, "_timeout"}, timeout, t);
    chk({tag, "_bus_err"}, bus_err, b);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_wstrb"}, wstrb, 1'b0);
    chk({tag, "_address"}, address, 8'h00);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    flags(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int s, np;
    repeat (3) @(negedge clk);
    reset_vals("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    reset_vals("idle");

    // nominal: lock on first poll
    lock_after = 1; err_poll = 0; sat_val = 1'b0;
    kick(26'h2620000, 2'd1, 1'b0, 1'b1, s);
    push(1'b0, A_LOCK, 32'h0, s + 16 + PG);
    push(1'b0, A_SAT, 32'h0, s + 19 + PG);
    wait_done("nom", s + 22 + PG);
    flags("nom", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("nom_done_pulse", done, 1'b0);
    repeat (2) @(negedge clk);
    drain("nom");

    // lock on third poll, saturation flagged
    lock_after = 3; sat_val = 1'b1;
    kick(26'h155AAAA, 2'd2, 1'b0, 1'b1, s);
    for (int n = 0; n < 3; n++)
      push(1'b0, A_LOCK, 32'h0, s + 16 + PG + n * (PG + 3));
    push(1'b0, A_SAT, 32'h0, s + 19 + PG + 2 * (PG + 3));
    wait_done("lk3", s + 22 + PG + 2 * (PG + 3));
    flags("lk3", 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drain("lk3");

    // never locks: polling ends once the counter reaches TIMEOUT
    lock_after = 0; sat_val = 1'b0;
    np = 1;
    while (np * (PG + 3) - 1 < TO) np++;
    kick(26'h0000001, 2'd3, 1'b0, 1'b1, s);
    for (int n = 0; n < np; n++)
      push(1'b0, A_LOCK, 32'h0, s + 16 + PG + n * (PG + 3));
    push(1'b1, A_EN, 32'h0, s + 16 + np * (PG + 3));
    wait_done("tmo", s + 19 + np * (PG + 3));
    flags("tmo", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    drain("tmo");

    // lock read returns all-ones
    lock_after = 1; err_poll = 1;
    kick(26'h3FFFFFF, 2'd0, 1'b0, 1'b1, s);
    push(1'b0, A_LOCK, 32'h0, s + 16 + PG);
    push(1'b1, A_EN, 32'h0, s + 19 + PG);
    wait_done("berr", s + 22 + PG);
    flags("berr", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    drain("berr");

    // stop during the FCW write: FCW completes, MODE skipped
    err_poll = 0;
    kick(26'h1234567, 2'd1, 1'b0, 1'b0, s);
    push(1'b1, A_RST, 32'd1, s + 1);
    push(1'b1, A_RST, 32'd0, s + 4);
    push(1'b1, A_FCW, 32'h1234567, s + 7);
    repeat (7) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    push(1'b1, A_EN, 32'h0, s + 10);
    wait_done("stp", s + 13);
    flags("stp", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drain("stp");

    // start and stop together from idle: only the disable write
    kick(26'h2620000, 2'd1, 1'b1, 1'b0, s);
    push(1'b1, A_EN, 32'h0, s + 1);
    wait_done("ss", s + 4);
    chk("ss_locked", locked, 1'b0);
    repeat (3) @(negedge clk);
    drain("ss");

    // async reset in the middle of the first write
    kick(26'h2620000, 2'd1, 1'b0, 1'b0, s);
    push(1'b1, A_RST, 32'd1, s + 1);
    #1;
    chk("arst_pre_valid", valid, 1'b1);
    rst = 1'b1;
    #1;
    reset_vals("arst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    drain("arst");

    // full sequence after the reset
    lock_after = 1; sat_val = 1'b0;
    kick(26'h2620000, 2'd1, 1'b0, 1'b1, s);
    push(1'b0, A_LOCK, 32'h0, s + 16 + PG);
    push(1'b0, A_SAT, 32'h0, s + 19 + PG);
    wait_done("rerun", s + 22 + PG);
    flags("rerun", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drain("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adpll_cfg_master.md
# adpll_cfg_master

Bus-initiator that drives the ADPLL controller's CPU register port: on `start` it soft-resets the ADPLL, programs channel (FCW) and mode, enables the loop, then polls the lock flag until lock or timeout and reads the saturation flag. It sits between the SoC sequencer (or a test FSM) and the ADPLL register block. It removes per-channel CPU firmware from the radio bring-up path. It is the master side of the `valid/address/wdata/wstrb/rdata/ready` protocol.

## Interface
- `DATA_W`, 32, bus data width
- `POLL_GAP`, 16, idle cycles between successive lock polls (≥1)
- `TIMEOUT`, 1000000, max cycles from first poll to lock before abort (≥1)
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  1-cycle pulse; begin bring-up sequence (ignored while `busy`)
- `stop`  in  1  1-cycle pulse; disable ADPLL (write `ADPLL_EN`=0)
- `fcw`  in  `FCWW`  channel word, sampled on accepted `start`
- `mode`  in  2  ADPLL mode, sampled on accepted `start`
- `valid`  out  1  bus request
- `address`  out  `ADPLL_ADDR_W`  register address (`adpll_defines.vh` macros)
- `wdata`  out  DATA_W  write data
- `wstrb`  out  1  1 = write, 0 = read
- `rdata`  in  DATA_W  read data, valid when `ready`
- `ready`  in  1  responder acknowledge
- `busy`  out  1  sequence in progress
- `done`  out  1  1-cycle pulse at end of any sequence
- `locked`, `sat`, `timeout`, `bus_err`  out  1 each  sticky status, cleared on accepted `start`

## Operation
- States: IDLE, W_RST1, W_RST0, W_FCW, W_MODE, W_EN, P_WAIT, R_LOCK, R_SAT, W_DIS, FIN.
- Start sequence: W_RST1 (`ADPLL_SOFT_RST`←1) → W_RST0 (←0) → W_FCW (`FCW`←fcw, zero-extended) → W_MODE (`ADPLL_MODE`←mode) → W_EN (`ADPLL_EN`←1) → P_WAIT → R_LOCK.
- R_LOCK: rdata[0]=1 → `locked`=1, go R_SAT; else back to P_WAIT.
- R_SAT reads `ADPLL_SAT`; `sat`←rdata[0]; → FIN.
- Timeout: cycle counter starts at 0 on first P_WAIT entry, saturates. Entering P_WAIT with counter ≥ TIMEOUT sets `timeout` and goes to W_DIS instead of polling.
- W_DIS writes `ADPLL_EN`←0 → FIN. FIN pulses `done` for one cycle → IDLE.
- `bus_err`: any read where rdata[DATA_W-1:1] ≠ 0, e.g. unmapped-address all-ones. Sets `bus_err`, goes W_DIS.
- `stop`: latched as pending. It is acted on at the next transaction boundary, after the gap cycle, or immediately from IDLE/P_WAIT. It goes to W_DIS, then FIN. `locked` is cleared.
- `start` and `stop` in the same IDLE cycle: stop wins, start dropped. `start` while busy: ignored. `stop` while already in W_DIS/FIN: no extra write.

## Timing
- Reset values: `valid`=0, `wstrb`=0, `address`=0, `wdata`=0, `busy`=0, `done`=0, all status flags 0, state IDLE, counters 0. Async reset takes effect mid-transaction, and `valid` drops immediately.
- All outputs are registered.
- Transaction, fixed 3 cycles, responder latency 1:
  - cycle T: `valid`=1 with `address`/`wdata`/`wstrb` stable.
  - cycle T+1: `ready` seen with `valid`=1; rdata captured on that edge and `valid`←0.
  - cycle T+2: gap; `ready` ignored.
  - Next `valid` no earlier than T+3.
- `ready` is only honoured while `valid`=1. If `ready` is late, `valid` holds until it arrives; no timeout on the bus.
- Outside transactions, `wstrb`=0 and `address`/`wdata` hold their last value.
- `busy` rises the cycle after accepted `start` and falls with `done`.
- Lock found on first poll:
  - `start` at cycle 0; W_RST1 `valid` at cycle 1.
  - Five writes span cycles 1–15.
  - P_WAIT covers POLL_GAP cycles.
  - R_LOCK takes 3 cycles, then R_SAT takes 3 cycles.
  - `done` at cycle 22+POLL_GAP.

## Test plan
- Nominal: responder model locks immediately, `fcw`=26'h2620000, `mode`=1.
  - Expect writes in order SOFT_RST=1, SOFT_RST=0, FCW=0x2620000, MODE=1, EN=1, then one LOCK read and one SAT read.
  - Expect `locked`=1, `sat`=0, and `done` at cycle 22+POLL_GAP.
- Lock after 3 polls:
  - Expect three R_LOCK reads spaced exactly POLL_GAP+3 cycles apart.
  - With SAT=1, expect `sat`=1.
- Timeout: TIMEOUT=50, never lock.
  - Expect polls to stop once counter ≥50, then an EN=0 write.
  - Expect `timeout`=1, `locked`=0, and a `done` pulse.
- Bus error: LOCK read returns 0xFFFFFFFF.
  - Expect `bus_err`=1, an EN=0 write, and `done`.
- `stop` during the W_FCW transaction:
  - Expect the FCW write to complete, the next transaction to be EN=0, and no MODE write.
  - Also: `start`+`stop` in the same IDLE cycle → only the EN=0 write.
- Async `rst` asserted while `valid`=1:
  - Expect all outputs at reset values within the same cycle.
  - Expect a fresh `start` afterwards to run the full sequence correctly.
